// File: rtl/bitwise_pkg.sv
// bitwise_pkg: op-code constants, op type and FSM state type shared by the bitwise accumulator
package bitwise_pkg;
    typedef logic [2:0] op_t;
    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_NOT  = 3'd5;
    localparam op_t OP_ACC  = 3'd6;
    localparam op_t OP_RSVD = 3'd7;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/bitwise_op.sv
// bitwise_op: combinational per-op bitwise function; reserved op yields zero and flags an error
import bitwise_pkg::*;
module bitwise_op #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] res,
    output logic             err
);
    // select the bitwise function; accumulate beats contribute a|b
    always_comb begin
        res = '0;
        err = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NAND: res = ~(a & b);
            OP_NOR:  res = ~(a | b);
            OP_NOT:  res = ~a;
            OP_ACC:  res = a | b;
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/bitwise_accum.sv
// bitwise_accum: handshaked bitwise ALU with multi-beat OR-accumulate; BITWISE_ACCUM_PARITY_EN adds out_parity
import bitwise_pkg::*;
module bitwise_accum #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 8,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [CW-1:0]    out_count,
    output logic             out_err
`ifdef BITWISE_ACCUM_PARITY_EN
    ,
    output logic             out_parity
`endif
);
    state_t           state, state_nx;
    logic             rdy;
    logic [WIDTH-1:0] acc, res, fold, out_d;
    logic [CW-1:0]    cnt, cnt_inc, count_d;
    logic             err_acc, res_err, err_d, bad_op;
    logic             accept, start, beat, close_acc, load;

    bitwise_op #(.WIDTH(WIDTH)) u_op (
        .a   (in_a),
        .b   (in_b),
        .op  (op_t'(in_op)),
        .res (res),
        .err (res_err)
    );

    assign fold      = in_a | in_b;
    assign bad_op    = in_op != OP_ACC;
    assign cnt_inc   = cnt + CW'(1);
    assign accept    = in_valid & in_ready;
    // a result drained in HOLD lets a same-cycle beat start a new transaction
    assign start     = accept & (state == IDLE || state == HOLD);
    assign beat      = accept & (state == ACCUM);
    assign close_acc = in_last | (cnt_inc == CW'(MAX_BEATS));
    assign load      = start ? (bad_op | in_last) : (beat & close_acc);
    assign out_d     = start ? res : (acc | fold);
    assign count_d   = start ? CW'(1) : cnt_inc;
    assign err_d     = start ? res_err : (err_acc | bad_op);

    // state register; ready is held off until the first edge after reset release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rdy   <= 1'b0;
        end else begin
            state <= state_nx;
            rdy   <= 1'b1;
        end
    end

    // next-state: single-beat ops and closing beats go to HOLD, open accumulates stay in ACCUM
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (load ? HOLD : ACCUM) : IDLE;
            ACCUM:   state_nx = beat ? (close_acc ? HOLD : ACCUM) : ACCUM;
            HOLD:    state_nx = out_ready ? (start ? (load ? HOLD : ACCUM) : IDLE) : HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // handshake outputs derived from state
    always_comb begin
        in_ready  = rdy & ((state == HOLD) ? out_ready : 1'b1);
        out_valid = state == HOLD;
    end

    // accumulator, beat counter and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            cnt       <= '0;
            err_acc   <= 1'b0;
            out       <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else begin
            if (start) begin
                acc     <= fold;
                cnt     <= CW'(1);
                err_acc <= 1'b0;
            end else if (beat) begin
                acc     <= acc | fold;
                cnt     <= cnt_inc;
                err_acc <= err_acc | bad_op;
            end
            if (load) begin
                out       <= out_d;
                out_count <= count_d;
                out_err   <= err_d;
            end
        end
    end

`ifdef BITWISE_ACCUM_PARITY_EN
    // parity registered alongside the result so it is held with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_parity <= 1'b0;
        else if (load)
            out_parity <= ^out_d;
    end
`endif
endmodule

// File: tb/tb_bitwise_accum.sv
// tb_bitwise_accum: directed self-checking bench for bitwise_accum (WIDTH=16, MAX_BEATS=8)
module tb_bitwise_accum;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_err;
    logic [15:0] in_a, in_b, out;
    logic [2:0]  in_op;
    logic [3:0]  out_count;
`ifdef BITWISE_ACCUM_PARITY_EN
    logic        out_parity;
`endif
    int compared = 0;
    int mismatched = 0;

    bitwise_accum #(.WIDTH(16), .MAX_BEATS(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_count (out_count),
        .out_err   (out_err)
`ifdef BITWISE_ACCUM_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic last);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_last  = last;
    endtask

    task automatic check_res(input string tag, input logic [15:0] o, input logic [3:0] c, input logic e);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out"}, 64'(out), 64'(o));
        check({tag, "_count"}, 64'(out_count), 64'(c));
        check({tag, "_err"}, 64'(out_err), 64'(e));
`ifdef BITWISE_ACCUM_PARITY_EN
        check({tag, "_parity"}, 64'(out_parity), 64'(^o));
`endif
    endtask

    logic [2:0]  t_op  [7] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1};
    logic [15:0] t_exp [7] = '{16'h3030, 16'hCCCC, 16'hCFCF, 16'h0303, 16'h0F0F, 16'h0000, 16'hFCFC};
    logic        t_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        #2;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("rel_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("rel_ready_high", 64'(in_ready), 64'd1);

        drive(1'b1, 3'd1, 16'd18500, 16'd19264, 1'b0);
        tick();
        check_res("or1", 16'h4B44, 4'd1, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();
        check("or1_drain", 64'(out_valid), 64'd0);

        drive(1'b1, 3'd1, 16'd8400, 16'h8942, 1'b0);
        tick();
        check_res("or2", 16'hA9D2, 4'd1, 1'b0);
        check("or2_signed", 64'(signed'(out) == -16'sd22062), 64'd1);

        for (int i = 0; i < 7; i++) begin
            drive(1'b1, t_op[i], 16'hF0F0, 16'h3C3C, 1'b0);
            tick();
            check_res($sformatf("b2b_op%0d", t_op[i]), t_exp[i], 4'd1, t_err[i]);
        end
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();
        check("b2b_drain", 64'(out_valid), 64'd0);

        drive(1'b1, 3'd6, 16'd1, 16'd2, 1'b0);
        tick();
        check("acc3_b1_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 3'd6, 16'd4, 16'd8, 1'b0);
        tick();
        check("acc3_b2_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 3'd6, 16'd16, 16'd0, 1'b1);
        tick();
        check_res("acc3", 16'd31, 4'd3, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd6, 16'(1) << i, 16'h0, 1'b0);
            tick();
            if (i < 7)
                check($sformatf("max_b%0d_valid", i), 64'(out_valid), 64'd0);
        end
        check_res("max8", 16'h00FF, 4'd8, 1'b0);
        drive(1'b1, 3'd6, 16'h0100, 16'h0, 1'b0);
        tick();
        check("max9_new_txn", 64'(out_valid), 64'd0);
        drive(1'b1, 3'd6, 16'h0200, 16'h0, 1'b1);
        tick();
        check_res("max9_close", 16'h0300, 4'd2, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();

        drive(1'b1, 3'd6, 16'h0001, 16'h0, 1'b0);
        tick();
        drive(1'b1, 3'd0, 16'h0002, 16'h0, 1'b1);
        tick();
        check_res("acc_bad_op", 16'h0003, 4'd2, 1'b1);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();

        out_ready = 1'b0;
        drive(1'b1, 3'd2, 16'h00FF, 16'h0F0F, 1'b0);
        tick();
        check_res("hold_first", 16'h0FF0, 4'd1, 1'b0);
        drive(1'b1, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d_ready", i), 64'(in_ready), 64'd0);
            tick();
            check_res($sformatf("hold%0d", i), 16'h0FF0, 4'd1, 1'b0);
        end
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 16'd3, 16'd6, 1'b0);
        #1;
        check("hold_release_ready", 64'(in_ready), 64'd1);
        tick();
        check_res("hold_next", 16'd2, 4'd1, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();
        check("hold_drain", 64'(out_valid), 64'd0);

        drive(1'b1, 3'd6, 16'h0040, 16'h0, 1'b0);
        tick();
        drive(1'b1, 3'd6, 16'h0080, 16'h0, 1'b0);
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_count", 64'(out_count), 64'd0);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 3'd6, 16'd5, 16'd0, 1'b1);
        tick();
        check_res("post_rst", 16'd5, 4'd1, 1'b0);
        drive(1'b0, 3'd0, 16'h0, 16'h0, 1'b0);
        tick();
        check("post_rst_drain", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
